mult_div_ctrl: RTL

Iterative signed multiply/divide sequencer that owns the HI/LO result registers for the multicycle MIPS core. The main control unit pulses `start` with an operation select and the A/B operands. This block then runs a radix-2 Booth multiply or a restoring divide, one bit per clock, and signals completion with a one-cycle `done` pulse. Divide-by-zero is reported as an exception flag to the control unit, which raises it through its exception sequence.

---
 rtl/mult_div_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mult_div_ctrl.sv
// Iterative signed MULT (Booth radix-2) / DIV (restoring) sequencer owning HI/LO.
// Latency from start-sampling edge: MULT done in cycle WIDTH+1, DIV WIDTH+2, DIV-by-zero cycle 1.
// No backpressure: start is only accepted in IDLE; requests while busy are dropped, not queued.
module mult_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE,
    S_EXC
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // MULT: acc is the sign-extended upper product half, qreg the multiplier/lower half.
  // DIV:  acc is the partial remainder, qreg shifts dividend out and quotient in.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qreg;
  logic             qm1;
  // Multiplicand (sign-extended) for MULT, divisor magnitude (zero-extended) for DIV.
  logic [WIDTH:0]   mcand;
  logic             sa;
  logic             sb;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last;

  // Datapath for one Booth step, one restoring-divide step and operand magnitudes.
  always_comb begin
    booth_sum = acc;
    if (qreg[0] && !qm1) begin
      booth_sum = acc - mcand;
    end else if (!qreg[0] && qm1) begin
      booth_sum = acc + mcand;
    end
    div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    div_ge    = (div_shift >= mcand);
    div_rem   = div_ge ? (div_shift - mcand) : div_shift;
    a_mag     = a_in[WIDTH-1] ? -a_in : a_in;
    b_mag     = b_in[WIDTH-1] ? -b_in : b_in;
    last      = (cnt == CNT_W'(WIDTH - 1));
  end

  // Sequencer FSM with registered status outputs and HI/LO result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      qreg  <= '0;
      qm1   <= 1'b0;
      mcand <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          div0 <= 1'b0;
          if (start) begin
            cnt  <= '0;
            busy <= 1'b1;
            if (!op) begin
              acc   <= '0;
              qreg  <= b_in;
              qm1   <= 1'b0;
              mcand <= {a_in[WIDTH-1], a_in};
              state <= S_MULT;
            end else if (b_in == '0) begin
              done  <= 1'b1;
              div0  <= 1'b1;
              state <= S_EXC;
            end else begin
              acc   <= '0;
              qreg  <= a_mag;
              mcand <= {1'b0, b_mag};
              sa    <= a_in[WIDTH-1];
              sb    <= b_in[WIDTH-1];
              state <= S_DIV;
            end
          end
        end
        S_MULT: begin
          acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
          qm1  <= qreg[0];
          cnt  <= cnt + 1'b1;
          if (last) begin
            // Final shifted product goes straight to HI/LO so it is valid with done.
            hi    <= booth_sum[WIDTH:1];
            lo    <= {booth_sum[0], qreg[WIDTH-1:1]};
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DIV: begin
          acc  <= div_rem;
          qreg <= {qreg[WIDTH-2:0], div_ge};
          cnt  <= cnt + 1'b1;
          if (last) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          // Quotient negative when signs differ; remainder follows the dividend sign.
          lo    <= (sa ^ sb) ? -qreg : qreg;
          hi    <= sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE, S_EXC: begin
          done  <= 1'b0;
          div0  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          div0  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
